// File: rtl/pack_frame_fifo.sv
// pack_frame_fifo: dual-clock frame buffer. A frame is readable only after its last word is written.
// Gray-coded frame pointers cross the clock domains. An overflowing frame is dropped whole and counted in rdClk.
module pack_frame_fifo_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];
endmodule

module pack_frame_fifo #(
  parameter int DW          = 16,
  parameter int FRAMELOG2   = 3,
  parameter int DEPTHLOG2   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         rdClk,
  input  logic                         rst,
  input  logic                         wrClk,
  input  logic                         WdAvail,
  input  logic                         PacketReset,
  input  logic [DW-1:0]                PacketWd,
  output logic [DW-1:0]                DataVal,
  input  logic                         DataNext,
  output logic                         DataReady,
  input  logic                         DataFrameReset,
  output logic                         DataOverf,
  output logic [15:0]                  OverfCount,
  output logic [DEPTHLOG2-FRAMELOG2:0] FramesAvail
);
  localparam int FPW = DEPTHLOG2 - FRAMELOG2 + 1;
  localparam logic [FPW-1:0] NF_PTR = {1'b1, {(FPW-1){1'b0}}};

  function automatic logic [FPW-1:0] bin2gray(input logic [FPW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FPW-1:0] gray2bin(input logic [FPW-1:0] g);
    logic [FPW-1:0] b;
    b[FPW-1] = g[FPW-1];
    for (int i = FPW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DW-1:0] mem [2**DEPTHLOG2];

  // write side (wrClk)
  logic [FPW-1:0]       wfp, wfpNext, wfpGray, rfpGraySync, rfpSyncW;
  logic [FRAMELOG2-1:0] woff, woffNext;
  logic                 drop, dropNext, dropNow, ovfTog, ovfTogNext, we, full;

  assign rfpSyncW = gray2bin(rfpGraySync);
  assign full     = (wfp - rfpSyncW) == NF_PTR;

  always_comb begin
    wfpNext    = wfp;
    woffNext   = woff;
    dropNext   = drop;
    ovfTogNext = ovfTog;
    we         = 1'b0;
    dropNow    = (woff == '0) ? full : drop;
    if (PacketReset) begin
      woffNext = '0;
      dropNext = 1'b0;
    end else if (WdAvail) begin
      dropNext = dropNow;
      we       = !dropNow;
      woffNext = woff + 1'b1;
      if (&woff) begin
        if (dropNow) ovfTogNext = ~ovfTog;
        else         wfpNext    = wfp + 1'b1;
      end
    end
  end

  always_ff @(posedge wrClk or posedge rst) begin
    if (rst) begin
      wfp     <= '0;
      woff    <= '0;
      drop    <= 1'b0;
      ovfTog  <= 1'b0;
      wfpGray <= '0;
    end else begin
      wfp     <= wfpNext;
      woff    <= woffNext;
      drop    <= dropNext;
      ovfTog  <= ovfTogNext;
      wfpGray <= bin2gray(wfpNext);
    end
  end

  always_ff @(posedge wrClk) begin
    if (we) mem[{wfp[FPW-2:0], woff}] <= PacketWd;
  end

  // read side (rdClk)
  logic [FPW-1:0]       rfp, rfpNext, rfpGray, wfpGraySync, wfpSyncR;
  logic [FRAMELOG2-1:0] roff, roffNext;
  logic                 advance, empty, ovfSync, ovfPrev, ovfEdge;

  assign wfpSyncR    = gray2bin(wfpGraySync);
  assign empty       = wfpSyncR == rfp;
  assign FramesAvail = wfpSyncR - rfp;
  assign ovfEdge     = ovfSync ^ ovfPrev;

  always_comb begin
    rfpNext  = rfp;
    roffNext = roff;
    advance  = DataNext && DataReady && !DataFrameReset;
    if (DataFrameReset) begin
      roffNext = '0;
    end else if (advance) begin
      roffNext = roff + 1'b1;
      if (&roff) rfpNext = rfp + 1'b1;
    end
  end

  // DataVal is fetched from the pre-update position, so any move hides DataReady for one refetch cycle
  always_ff @(posedge rdClk or posedge rst) begin
    if (rst) begin
      rfp        <= '0;
      roff       <= '0;
      rfpGray    <= '0;
      DataVal    <= '0;
      DataReady  <= 1'b0;
      ovfPrev    <= 1'b0;
      DataOverf  <= 1'b0;
      OverfCount <= '0;
    end else begin
      rfp       <= rfpNext;
      roff      <= roffNext;
      rfpGray   <= bin2gray(rfpNext);
      DataVal   <= mem[{rfp[FPW-2:0], roff}];
      DataReady <= !empty && !(DataFrameReset || advance);
      ovfPrev   <= ovfSync;
      DataOverf <= ovfEdge;
      if (ovfEdge && !(&OverfCount)) OverfCount <= OverfCount + 1'b1;
    end
  end

  pack_frame_fifo_sync #(.W(FPW), .STAGES(SYNC_STAGES)) uWfpSync (
    .clk(rdClk), .rst(rst), .d(wfpGray), .q(wfpGraySync)
  );
  pack_frame_fifo_sync #(.W(FPW), .STAGES(SYNC_STAGES)) uRfpSync (
    .clk(wrClk), .rst(rst), .d(rfpGray), .q(rfpGraySync)
  );
  pack_frame_fifo_sync #(.W(1), .STAGES(SYNC_STAGES)) uOvfSync (
    .clk(rdClk), .rst(rst), .d(ovfTog), .q(ovfSync)
  );
endmodule

// File: tb/tb_pack_frame_fifo.sv
// Bench for pack_frame_fifo: a default-size and a 4-frame instance, checked against a word-queue model.
`timescale 1ns/1ps
module tb_pack_frame_fifo;
  localparam int FW = 8;
  localparam int NSTREAM = 400;

  logic rdClk = 0, wrClk = 0, rst = 1;
  logic WdAvail = 0, PacketReset = 0, DataNext = 0, DataFrameReset = 0;
  logic [15:0] PacketWd = '0;
  logic sel = 0;
  real wrHalf = 10.417, rdHalf = 5.0;

  logic [15:0] dvB, dvS, ocB, ocS, dv, oc;
  logic rdyB, rdyS, ovB, ovS, rdy, ov;
  logic [9:0] faB, fa;
  logic [2:0] faS;

  assign dv  = sel ? dvS : dvB;
  assign oc  = sel ? ocS : ocB;
  assign rdy = sel ? rdyS : rdyB;
  assign ov  = sel ? ovS : ovB;
  assign fa  = sel ? {7'd0, faS} : faB;

  pack_frame_fifo uBig (
    .rdClk(rdClk), .rst(rst), .wrClk(wrClk),
    .WdAvail(WdAvail && !sel), .PacketReset(PacketReset && !sel), .PacketWd(PacketWd),
    .DataVal(dvB), .DataNext(DataNext && !sel), .DataReady(rdyB),
    .DataFrameReset(DataFrameReset && !sel), .DataOverf(ovB), .OverfCount(ocB), .FramesAvail(faB)
  );

  pack_frame_fifo #(.DEPTHLOG2(5)) uSmall (
    .rdClk(rdClk), .rst(rst), .wrClk(wrClk),
    .WdAvail(WdAvail && sel), .PacketReset(PacketReset && sel), .PacketWd(PacketWd),
    .DataVal(dvS), .DataNext(DataNext && sel), .DataReady(rdyS),
    .DataFrameReset(DataFrameReset && sel), .DataOverf(ovS), .OverfCount(ocS), .FramesAvail(faS)
  );

  initial forever #(wrHalf) wrClk = ~wrClk;
  initial forever #(rdHalf) rdClk = ~rdClk;

  int errors = 0, checks = 0;
  logic [15:0] expQ[$];
  int framesIn = 0, wordsOut = 0, dropsExp = 0;
  int ovfTotal = 0, ovfBase = 0;

  always @(negedge rdClk) if (!rst && ovS === 1'b1) ovfTotal++;

  function automatic int nfCur();
    return sel ? 4 : 512;
  endfunction

  function automatic int inFlight();
    return framesIn - wordsOut / FW;
  endfunction

  task automatic model_clear();
    expQ.delete();
    framesIn = 0; wordsOut = 0; dropsExp = 0;
    ovfBase = ovfTotal;
  endtask

  task automatic do_reset();
    rst = 1; WdAvail = 0; PacketReset = 0; DataNext = 0; DataFrameReset = 0;
    repeat (3) @(posedge rdClk);
    repeat (2) @(posedge wrClk);
    #1 rst = 0;
    model_clear();
    repeat (3) @(posedge rdClk);
    #1;
  endtask

  // nw < FW leaves a partial frame that must never become visible
  task automatic push_frame(input logic [15:0] base, input int nw, input int gapPct);
    bit dropIt;
    dropIt = inFlight() >= nfCur();
    for (int i = 0; i < nw; i++) begin
      while (int'($urandom_range(99)) < gapPct) begin
        @(posedge wrClk); #1 WdAvail = 0;
      end
      @(posedge wrClk); #1;
      WdAvail = 1; PacketWd = base + 16'(i);
    end
    @(posedge wrClk); #1 WdAvail = 0;
    if (nw == FW) begin
      if (dropIt) dropsExp++;
      else begin
        for (int i = 0; i < FW; i++) expQ.push_back(base + 16'(i));
        framesIn++;
      end
    end
  endtask

  task automatic read_words(input int n, input int pct);
    int got, cyc;
    bit took;
    logic [15:0] e;
    got = 0; cyc = 0; took = 0;
    while (got < n && cyc < n * 40 + 200) begin
      @(posedge rdClk); #1; cyc++;
      if (took) begin
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL refetch_gap: DataReady=%b after consume, expected 0", rdy); end
      end
      took = 0;
      DataNext = (int'($urandom_range(99)) < pct);
      if (rdy === 1'b1 && DataNext) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("FAIL read_word: DataVal=%h readable, expected no data", dv);
        end else begin
          e = expQ.pop_front();
          if (dv !== e) begin errors++; $display("FAIL read_word: DataVal=%h expected %h (word %0d)", dv, e, wordsOut); end
        end
        wordsOut++; got++; took = 1;
      end
    end
    @(posedge rdClk); #1;
    DataNext = 0;
    if (took) begin
      checks++;
      if (rdy !== 1'b0) begin errors++; $display("FAIL refetch_gap: DataReady=%b after consume, expected 0", rdy); end
    end
    if (got < n) begin
      errors++; checks++;
      $display("FAIL read_timeout: read %0d words, expected %0d", got, n);
    end
  endtask

  task automatic wait_ready(input int maxCyc, output int cyc);
    cyc = 0;
    while (rdy !== 1'b1 && cyc < maxCyc) begin
      @(posedge rdClk); #1; cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge rdClk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #0;
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", s, rdy); end
      checks++; if (dv !== 16'h0) begin errors++; $display("FAIL reset_dataval[%0d]: got %h expected 0000", s, dv); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_overf[%0d]: got %b expected 0", s, ov); end
      checks++; if (oc !== 16'h0) begin errors++; $display("FAIL reset_overfcount[%0d]: got %0d expected 0", s, oc); end
      checks++; if (fa !== 10'd0) begin errors++; $display("FAIL reset_framesavail[%0d]: got %0d expected 0", s, fa); end
    end
    sel = 0;
    #1 rst = 0;
    model_clear();
    repeat (5) @(posedge rdClk);
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", rdy); end
  endtask

  task automatic test_basic();
    int lat;
    sel = 0;
    push_frame(16'h0100, FW, 0);
    wait_ready(20, lat);
    checks++;
    if (rdy !== 1'b1 || lat > 5) begin errors++; $display("FAIL commit_latency: ready=%b after %0d rdClk, expected 1 within 5", rdy, lat); end
    checks++; if (fa !== 10'(inFlight())) begin errors++; $display("FAIL basic_avail: got %0d expected %0d", fa, inFlight()); end
    read_words(FW, 100);
    repeat (4) @(posedge rdClk);
    #1;
    checks++; if (fa !== 10'd0) begin errors++; $display("FAIL basic_avail_drain: got %0d expected 0", fa); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL basic_ready_drain: got %b expected 0", rdy); end
  endtask

  task automatic test_packet_reset();
    int lat;
    sel = 0;
    push_frame(16'h0200, 5, 0);
    @(posedge wrClk); #1;
    WdAvail = 1; PacketReset = 1; PacketWd = 16'hDEAD;
    @(posedge wrClk); #1;
    WdAvail = 0; PacketReset = 0;
    push_frame(16'h0210, FW, 20);
    wait_ready(20, lat);
    repeat (2) @(posedge rdClk);
    #1;
    checks++; if (fa !== 10'd1) begin errors++; $display("FAIL pktreset_avail: got %0d expected 1", fa); end
    read_words(FW, 100);
    repeat (4) @(posedge rdClk);
    #1;
    checks++; if (rdy !== 1'b0 || fa !== 10'd0) begin errors++; $display("FAIL pktreset_drain: ready=%b avail=%0d expected 0/0", rdy, fa); end
  endtask

  task automatic test_rewind();
    int lat;
    sel = 0;
    push_frame(16'h0300, FW, 0);
    wait_ready(20, lat);
    read_words(3, 100);
    wait_ready(10, lat);
    DataNext = 1; DataFrameReset = 1;
    @(posedge rdClk); #1;
    DataNext = 0; DataFrameReset = 0;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rewind_gap: DataReady=%b expected 0", rdy); end
    @(posedge rdClk); #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rewind_one_cycle: DataReady=%b expected 1", rdy); end
    checks++; if (dv !== 16'h0300) begin errors++; $display("FAIL rewind_word0: DataVal=%h expected 0300", dv); end
    for (int i = 2; i >= 0; i--) expQ.push_front(16'h0300 + 16'(i));
    wordsOut -= 3;
    read_words(FW, 60);
  endtask

  task automatic test_overflow();
    sel = 1;
    do_reset();
    for (int f = 0; f < 6; f++) push_frame(16'h0400 + 16'(f * FW), FW, 0);
    repeat (20) @(posedge rdClk);
    #1;
    checks++; if (dropsExp != 2) begin errors++; $display("FAIL ovf_model: model drops %0d expected 2", dropsExp); end
    checks++; if (ovfTotal - ovfBase !== dropsExp) begin errors++; $display("FAIL ovf_pulses: got %0d expected %0d", ovfTotal - ovfBase, dropsExp); end
    checks++; if (oc !== 16'(dropsExp)) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", oc, dropsExp); end
    checks++; if (fa !== 10'(inFlight())) begin errors++; $display("FAIL ovf_avail: got %0d expected %0d", fa, inFlight()); end
    read_words(4 * FW, 100);
    repeat (4) @(posedge rdClk);
    #1;
    checks++; if (fa !== 10'd0) begin errors++; $display("FAIL ovf_drain: got %0d expected 0", fa); end
  endtask

  task automatic test_wrap_stream();
    int guard;
    sel = 1;
    wrHalf = 5.0; rdHalf = 15.0;
    do_reset();
    fork
      begin
        for (int f = 0; f < NSTREAM; f++) begin
          guard = 0;
          while (inFlight() >= nfCur() && guard < 20000) begin @(posedge wrClk); guard++; end
          repeat (16) @(posedge wrClk);
          push_frame(16'(f * FW), FW, 15);
        end
      end
      read_words(NSTREAM * FW, 70);
    join
    repeat (6) @(posedge rdClk);
    #1;
    checks++; if (oc !== 16'd0) begin errors++; $display("FAIL stream_overf: got %0d expected 0", oc); end
    checks++; if (ovfTotal != ovfBase) begin errors++; $display("FAIL stream_pulses: got %0d expected 0", ovfTotal - ovfBase); end
    checks++; if (fa !== 10'd0 || rdy !== 1'b0) begin errors++; $display("FAIL stream_drain: avail=%0d ready=%b expected 0/0", fa, rdy); end
    wrHalf = 10.417; rdHalf = 5.0;
  endtask

  task automatic test_reset_midframe();
    int lat;
    sel = 0;
    do_reset();
    push_frame(16'h0600, FW, 0);
    push_frame(16'h0610, 3, 0);
    wait_ready(20, lat);
    read_words(2, 100);
    WdAvail = 1; PacketWd = 16'h0666; DataNext = 1;
    #2 rst = 1;
    @(posedge rdClk); #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", rdy); end
    checks++; if (dv !== 16'h0) begin errors++; $display("FAIL midrst_dataval: got %h expected 0000", dv); end
    checks++; if (ov !== 1'b0 || oc !== 16'h0) begin errors++; $display("FAIL midrst_overf: got %b/%0d expected 0/0", ov, oc); end
    checks++; if (fa !== 10'd0) begin errors++; $display("FAIL midrst_avail: got %0d expected 0", fa); end
    WdAvail = 0; DataNext = 0;
    repeat (3) @(posedge rdClk);
    #1 rst = 0;
    model_clear();
    repeat (3) @(posedge rdClk);
    push_frame(16'h0700, FW, 0);
    wait_ready(20, lat);
    repeat (2) @(posedge rdClk);
    #1;
    checks++; if (fa !== 10'd1) begin errors++; $display("FAIL midrst_newframe_avail: got %0d expected 1", fa); end
    read_words(FW, 100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_packet_reset();
    test_rewind();
    test_overflow();
    test_wrap_stream();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
